fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch sequencer for the single-issue RV32I pipeline. Owns the program counter, drives the 6-bit word address of the 64-entry instruction ROM and captures the returned word into the IF/ID pipeline register. Applies hazard-unit stalls and EX-stage redirects (taken branch, jal, jalr). Detects the self-loop halt idiom (`jal xN, 0` jumping to itself) and parks the front end.

## Interface
- Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ROM_AW, 6, ROM word-address width; ROM window is bytes 0 .. 4*2^ROM_AW-1
- HALT_ON_LOOP, 1, when 1 a self-loop redirect enters HALTED
- Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- rom_addr  out  ROM_AW  word address to ROM, = pc[ROM_AW+1:2]
- rom_dout  in  32  combinational ROM data for rom_addr
- stall  in  1  hold PC and IF/ID (load-use hazard)
- redirect_valid  in  1  EX-stage control transfer taken
- redirect_pc  in  32  target byte address
- redirect_src_pc  in  32  PC of the redirecting instruction
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_inst  out  32  IF/ID instruction; 32'h0 when invalid
- ifid_pc  out  32  IF/ID instruction PC
- pc  out  32  current fetch PC
- halted  out  1  front end parked
- err_oob  out  1  sticky: fetch outside ROM window
- err_misalign  out  1  sticky: redirect_pc[1:0] != 0
- cnt_fetch, cnt_stall, cnt_flush  out  16 each  performance counters (see Configuration)

## Operation
- FSM states: IDLE, FETCH, HALTED. Reset enters IDLE.
- IDLE: one cycle, nothing captured, ifid_valid=0; then FETCH unconditionally.
- FETCH, per-cycle priority: redirect > stall > advance.
- Redirect: pc <= {redirect_pc[31:2], 2'b00}. IF/ID flushed: ifid_valid=0, ifid_inst=0, ifid_pc=0. Set err_misalign if redirect_pc[1:0] != 0. Flushing ID/EX is the hazard unit's job, not this block's.
- Self-loop: if HALT_ON_LOOP=1 and redirect_pc == redirect_src_pc, the redirect is applied as above and the next state is HALTED.
- Stall, no redirect: pc and IF/ID hold their values.
- Advance: ifid_inst <= rom_dout (or 0 if out of window), ifid_pc <= pc, ifid_valid <= 1, pc <= pc+4 (32-bit wrap).
- Out of window: pc[31:ROM_AW+2] != 0 when advancing. Captures nop 32'h0 with ifid_valid=1 and sets err_oob.
- HALTED:
  - pc frozen; ifid_valid=0.
  - stall and redirect ignored.
  - Exit only by rst.
- Sticky flags clear only on rst.

## Timing
- Reset values:
  - pc=RESET_PC; state=IDLE.
  - ifid_valid=0, ifid_inst=0, ifid_pc=0.
  - halted=0, err_oob=0, err_misalign=0.
  - all counters 0.
- rom_addr is combinational from the pc register. The ROM word is captured on the same edge that advances pc, so fetch latency is 1 cycle from pc to IF/ID.
- First valid IF/ID: 2nd rising edge after rst deasserts. The 1st edge only performs IDLE -> FETCH.
- Redirect penalty: the cycle after redirect, IF/ID is a bubble. The target instruction is valid in IF/ID one cycle later.
- redirect_valid and stall in the same cycle: the redirect is taken and stall is ignored for that cycle.
- rst asserted mid-stall or mid-redirect: reset values on that edge; in-flight state is discarded.
- halted goes high the cycle after the self-loop redirect.

## Configuration
- FETCH_PERF_EN defined:
  - cnt_fetch increments on each advance.
  - cnt_stall increments on each cycle where stall holds in FETCH.
  - cnt_flush increments on each redirect.
  - All three saturate at 16'hFFFF and reset to 0.
- FETCH_PERF_EN undefined: the counters are not instantiated and the three ports are tied to 16'h0. Ports are retained so top-level wiring is unchanged.

## Structure
- Shared package `fetch_pkg`:
  - FSM state enum (IDLE/FETCH/HALTED).
  - NOP constant 32'h0000_0000.
  - IF/ID register struct {valid, inst, pc}.
- Sub-module `sat_counter16` (enable, rst, clk, count out), instantiated three times under FETCH_PERF_EN.

## Test plan
- Reset then run: after the 2nd edge, ifid_pc=0x00, ifid_inst=32'h00003f37, ifid_valid=1. Next cycle ifid_pc=0x04, ifid_inst=32'h02000fe7.
- Redirect_valid with redirect_pc=0x20, src=0x04: the next cycle has ifid_valid=0. The following cycle has ifid_pc=0x20, ifid_inst=32'h00001c63. cnt_flush=1.
- Stall held 3 cycles at pc=0x0C: pc and IF/ID are unchanged for 3 cycles, then resume at 0x10. cnt_stall=3.
- Stall and redirect together (target 0x08): the redirect wins, and IF/ID at 0x08 has inst 32'h01c02623.
- Self-loop, redirect_pc=redirect_src_pc=0x1C: halted=1 the next cycle, pc=0x1C, ifid_valid=0 thereafter, further redirects ignored. Exit via rst.
- Out-of-window and misaligned:
  - Redirect to 0x102: err_misalign=1; pc=0x100.
  - Next advance captures ifid_inst=0 with valid=1, and err_oob=1.
  - Both flags stay set until rst.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalted
  } fetch_state_e;

  localparam logic [31:0] Nop = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } ifid_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that saturates at all-ones; synchronous active-high reset.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (enable && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: PC, ROM addressing, IF/ID register, redirect/stall, self-loop halt.
// Performance counters are built only when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ROM_AW       = 6,
  parameter bit          HALT_ON_LOOP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_dout,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic [31:0]       redirect_src_pc,
  output logic              ifid_valid,
  output logic [31:0]       ifid_inst,
  output logic [31:0]       ifid_pc,
  output logic [31:0]       pc,
  output logic              halted,
  output logic              err_oob,
  output logic              err_misalign,
  output logic [15:0]       cnt_fetch,
  output logic [15:0]       cnt_stall,
  output logic [15:0]       cnt_flush
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  ifid_t        ifid_q, ifid_d;
  logic         err_oob_q, err_oob_d;
  logic         err_misalign_q, err_misalign_d;

  logic in_fetch;
  logic take_redirect;
  logic self_loop;
  logic out_of_window;

  assign in_fetch      = (state_q == StFetch);
  assign take_redirect = in_fetch & redirect_valid;
  assign self_loop     = HALT_ON_LOOP && (redirect_pc == redirect_src_pc);
  assign out_of_window = (pc_q[31:ROM_AW+2] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (take_redirect && self_loop) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  // Redirect outranks stall, stall outranks advance; IDLE and HALTED keep IF/ID empty.
  always_comb begin
    pc_d           = pc_q;
    ifid_d         = ifid_q;
    err_oob_d      = err_oob_q;
    err_misalign_d = err_misalign_q;
    unique case (state_q)
      StFetch: begin
        if (redirect_valid) begin
          pc_d   = {redirect_pc[31:2], 2'b00};
          ifid_d = '0;
          if (redirect_pc[1:0] != 2'b00) err_misalign_d = 1'b1;
        end else if (!stall) begin
          ifid_d.valid = 1'b1;
          ifid_d.inst  = out_of_window ? Nop : rom_dout;
          ifid_d.pc    = pc_q;
          pc_d         = pc_q + 32'd4;
          if (out_of_window) err_oob_d = 1'b1;
        end
      end
      default: ifid_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      ifid_q         <= '0;
      err_oob_q      <= 1'b0;
      err_misalign_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      ifid_q         <= ifid_d;
      err_oob_q      <= err_oob_d;
      err_misalign_q <= err_misalign_d;
    end
  end

  assign rom_addr     = pc_q[ROM_AW+1:2];
  assign pc           = pc_q;
  assign ifid_valid   = ifid_q.valid;
  assign ifid_inst    = ifid_q.inst;
  assign ifid_pc      = ifid_q.pc;
  assign halted       = (state_q == StHalted);
  assign err_oob      = err_oob_q;
  assign err_misalign = err_misalign_q;

`ifdef FETCH_PERF_EN
  logic take_stall;
  logic take_advance;

  assign take_stall   = in_fetch & ~redirect_valid & stall;
  assign take_advance = in_fetch & ~redirect_valid & ~stall;

  sat_counter16 u_cnt_fetch (
    .clk    (clk),
    .rst    (rst),
    .enable (take_advance),
    .count  (cnt_fetch)
  );

  sat_counter16 u_cnt_stall (
    .clk    (clk),
    .rst    (rst),
    .enable (take_stall),
    .count  (cnt_stall)
  );

  sat_counter16 u_cnt_flush (
    .clk    (clk),
    .rst    (rst),
    .enable (take_redirect),
    .count  (cnt_flush)
  );
`else
  assign cnt_fetch = 16'h0;
  assign cnt_stall = 16'h0;
  assign cnt_flush = 16'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, run, redirect, stall, halt, out-of-window/misaligned.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  rom_addr;
  logic [31:0] rom_dout;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] redirect_src_pc = 32'h0;
  logic        ifid_valid;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic [31:0] pc;
  logic        halted;
  logic        err_oob;
  logic        err_misalign;
  logic [15:0] cnt_fetch, cnt_stall, cnt_flush;

  int errors = 0;
  int checks = 0;

`ifdef FETCH_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic [31:0] rom [64];
  assign rom_dout = rom[rom_addr];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC     (32'h0000_0000),
    .ROM_AW       (6),
    .HALT_ON_LOOP (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_addr        (rom_addr),
    .rom_dout        (rom_dout),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_src_pc (redirect_src_pc),
    .ifid_valid      (ifid_valid),
    .ifid_inst       (ifid_inst),
    .ifid_pc         (ifid_pc),
    .pc              (pc),
    .halted          (halted),
    .err_oob         (err_oob),
    .err_misalign    (err_misalign),
    .cnt_fetch       (cnt_fetch),
    .cnt_stall       (cnt_stall),
    .cnt_flush       (cnt_flush)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    stall = 1'b0;
    redirect_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset(input string tag);
    do_reset();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL %s_pc: got %h want %h", tag, pc, 32'h0); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL %s_valid: got %b want 0", tag, ifid_valid); end
    checks++; if (ifid_inst !== 32'h0) begin errors++; $display("FAIL %s_inst: got %h want 0", tag, ifid_inst); end
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL %s_ifid_pc: got %h want 0", tag, ifid_pc); end
    checks++; if ({halted, err_oob, err_misalign} !== 3'b000) begin errors++;
      $display("FAIL %s_flags: got %b want 000", tag, {halted, err_oob, err_misalign}); end
    checks++; if ({cnt_fetch, cnt_stall, cnt_flush} !== 48'h0) begin errors++;
      $display("FAIL %s_cnts: got %h want 0", tag, {cnt_fetch, cnt_stall, cnt_flush}); end
  endtask

  task automatic test_run();
    logic [15:0] exp;
    step();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL run_idle_valid: got %b want 0", ifid_valid); end
    step();
    checks++; if ({ifid_valid, ifid_pc, ifid_inst} !== {1'b1, 32'h0, 32'h00003f37}) begin errors++;
      $display("FAIL run_first: got %b %h %h want 1 0 00003f37", ifid_valid, ifid_pc, ifid_inst); end
    step();
    checks++; if ({ifid_valid, ifid_pc, ifid_inst} !== {1'b1, 32'h4, 32'h02000fe7}) begin errors++;
      $display("FAIL run_second: got %b %h %h want 1 4 02000fe7", ifid_valid, ifid_pc, ifid_inst); end
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL run_pc: got %h want 8", pc); end
    exp = PerfEn ? 16'd2 : 16'd0;
    checks++; if (cnt_fetch !== exp) begin errors++; $display("FAIL run_cnt_fetch: got %0d want %0d", cnt_fetch, exp); end
  endtask

  task automatic test_redirect();
    logic [15:0] exp;
    redirect_valid = 1'b1; redirect_pc = 32'h20; redirect_src_pc = 32'h04;
    step();
    redirect_valid = 1'b0;
    checks++; if ({ifid_valid, ifid_inst, ifid_pc} !== 65'h0) begin errors++;
      $display("FAIL redir_bubble: got %b %h %h want 0 0 0", ifid_valid, ifid_inst, ifid_pc); end
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL redir_pc: got %h want 20", pc); end
    step();
    checks++; if ({ifid_valid, ifid_pc, ifid_inst} !== {1'b1, 32'h20, 32'h00001c63}) begin errors++;
      $display("FAIL redir_target: got %b %h %h want 1 20 00001c63", ifid_valid, ifid_pc, ifid_inst); end
    exp = PerfEn ? 16'd1 : 16'd0;
    checks++; if (cnt_flush !== exp) begin errors++; $display("FAIL redir_cnt_flush: got %0d want %0d", cnt_flush, exp); end
  endtask

  task automatic test_stall();
    logic [15:0] exp;
    redirect_valid = 1'b1; redirect_pc = 32'h08; redirect_src_pc = 32'h24;
    step();
    redirect_valid = 1'b0;
    step();
    // pc=0x0C with the 0x08 instruction sitting in IF/ID
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({pc, ifid_valid, ifid_pc, ifid_inst} !== {32'h0C, 1'b1, 32'h08, 32'h01c02623}) begin errors++;
        $display("FAIL stall_hold%0d: got %h %b %h %h want c 1 8 01c02623", i, pc, ifid_valid, ifid_pc, ifid_inst); end
    end
    stall = 1'b0;
    step();
    checks++; if ({pc, ifid_pc, ifid_inst} !== {32'h10, 32'h0C, 32'hA000_0003}) begin errors++;
      $display("FAIL stall_resume: got %h %h %h want 10 c a0000003", pc, ifid_pc, ifid_inst); end
    exp = PerfEn ? 16'd3 : 16'd0;
    checks++; if (cnt_stall !== exp) begin errors++; $display("FAIL stall_cnt: got %0d want %0d", cnt_stall, exp); end
  endtask

  task automatic test_stall_and_redirect();
    logic [15:0] exp;
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h08; redirect_src_pc = 32'h30;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    checks++; if ({pc, ifid_valid} !== {32'h08, 1'b0}) begin errors++;
      $display("FAIL sr_redirect: got %h %b want 8 0", pc, ifid_valid); end
    step();
    checks++; if ({ifid_valid, ifid_pc, ifid_inst} !== {1'b1, 32'h08, 32'h01c02623}) begin errors++;
      $display("FAIL sr_target: got %b %h %h want 1 8 01c02623", ifid_valid, ifid_pc, ifid_inst); end
    exp = PerfEn ? 16'd3 : 16'd0;
    checks++; if (cnt_stall !== exp) begin errors++; $display("FAIL sr_cnt_stall: got %0d want %0d", cnt_stall, exp); end
    checks++; if (cnt_flush !== exp) begin errors++; $display("FAIL sr_cnt_flush: got %0d want %0d", cnt_flush, exp); end
  endtask

  task automatic test_oob_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h102; redirect_src_pc = 32'h0C;
    step();
    redirect_valid = 1'b0;
    checks++; if ({err_misalign, err_oob, pc} !== {2'b10, 32'h100}) begin errors++;
      $display("FAIL mis_redirect: got %b %b %h want 1 0 100", err_misalign, err_oob, pc); end
    step();
    checks++; if ({ifid_valid, ifid_pc, ifid_inst} !== {1'b1, 32'h100, 32'h0}) begin errors++;
      $display("FAIL oob_capture: got %b %h %h want 1 100 0", ifid_valid, ifid_pc, ifid_inst); end
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_flag: got %b want 1", err_oob); end
    redirect_valid = 1'b1; redirect_pc = 32'h00; redirect_src_pc = 32'h104;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    checks++; if ({err_oob, err_misalign, ifid_pc, ifid_inst} !== {2'b11, 32'h04, 32'h02000fe7}) begin errors++;
      $display("FAIL flags_sticky: got %b %b %h %h want 1 1 4 02000fe7", err_oob, err_misalign, ifid_pc, ifid_inst); end
  endtask

  task automatic test_self_loop();
    redirect_valid = 1'b1; redirect_pc = 32'h1C; redirect_src_pc = 32'h1C;
    step();
    redirect_valid = 1'b0;
    checks++; if ({halted, pc, ifid_valid} !== {1'b1, 32'h1C, 1'b0}) begin errors++;
      $display("FAIL loop_halt: got %b %h %b want 1 1c 0", halted, pc, ifid_valid); end
    for (int i = 0; i < 3; i++) begin
      redirect_valid = (i != 1); stall = (i == 1); redirect_pc = 32'h40; redirect_src_pc = 32'h0;
      step();
      checks++; if ({halted, pc, ifid_valid, ifid_inst} !== {1'b1, 32'h1C, 1'b0, 32'h0}) begin errors++;
        $display("FAIL loop_parked%0d: got %b %h %b %h want 1 1c 0 0", i, halted, pc, ifid_valid, ifid_inst); end
    end
    // leave stall and redirect asserted so the reset edge must discard them
    stall = 1'b1; redirect_valid = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + i;
    rom[0] = 32'h00003f37;
    rom[1] = 32'h02000fe7;
    rom[2] = 32'h01c02623;
    rom[8] = 32'h00001c63;

    test_reset("reset");
    test_run();
    test_redirect();
    test_stall();
    test_stall_and_redirect();
    test_oob_misalign();
    test_self_loop();
    test_reset("rereset");
    test_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
